match_referee: RTL

MATCH_REFEREE -- requirements
Module: match_referee

---
 rtl/fight_pkg.sv | 44 ++++
 rtl/round_timer.sv | 28 ++
 rtl/match_referee.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fight_pkg.sv
// fight_pkg: shared types for the match referee and its round timer.
//   state_t   - referee FSM states
//   WIN_*     - encodings of the winner output
//   action_t  - outcome of one FIGHT cycle, as judged from the lives inputs
//   MAX_LIVES - full lives a player starts each round with
package fight_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FIGHT,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_P1_PT,
        ACT_P2_PT,
        ACT_DRAW
    } action_t;

    localparam int MAX_LIVES = 3;

    // Round judgement; the order of the tests is the priority order.
    function automatic action_t judge(input logic [1:0] l1, input logic [1:0] l2,
                                      input logic timeout);
        if (l1 == 2'd0 && l2 == 2'd0) return ACT_DRAW;
        if (l1 == 2'd0)               return ACT_P2_PT;
        if (l2 == 2'd0)               return ACT_P1_PT;
        if (timeout) begin
            if (l1 > l2)              return ACT_P1_PT;
            if (l2 > l1)              return ACT_P2_PT;
            return ACT_DRAW;
        end
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/round_timer.sv
// round_timer: loadable up-counter shared by FIGHT timeout and HOLD counting.
//   clk, reset - clock, async active-high reset (count -> 0)
//   load       - clear the count to 0 (wins over en)
//   en         - count up by one
//   limit      - terminal count
//   expire     - high while the count equals limit
module round_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (load) cnt <= '0;
        else if (en)   cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == limit);

endmodule

// File: rtl/match_referee.sv
// match_referee: best-of-three referee around a two-player fight stage.
//   clk, reset   - clock, async active-high reset
//   start        - begins a match from IDLE or DONE
//   lives1/2     - player lives reported by the fight stage
//   game_reset_n - low restores the fight stage to full lives / start places
//   game_control - high lets the fight stage update
//   wins1/2      - rounds won per player
//   round_num    - current round 1..3, 0 when idle
//   winner       - 00 none, 01 P1, 10 P2, 11 draw
//   match_done   - high while in DONE
module match_referee
    import fight_pkg::*;
#(
    parameter int ROUNDS_TO_WIN = 2,
    parameter int ROUND_CYCLES  = 64,
    parameter int HOLD_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] lives1,
    input  logic [1:0] lives2,
    output logic       game_reset_n,
    output logic       game_control,
    output logic [1:0] wins1,
    output logic [1:0] wins2,
    output logic [1:0] round_num,
    output logic [1:0] winner,
    output logic       match_done
);

    localparam int TMAX = (ROUND_CYCLES > HOLD_CYCLES) ? ROUND_CYCLES : HOLD_CYCLES;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam logic [1:0]    R2W       = 2'(ROUNDS_TO_WIN);
    localparam logic [TW-1:0] FIGHT_LIM = TW'(ROUND_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LIM  = TW'(HOLD_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  wins1_n, wins2_n, round_n, winner_n;
    logic        tmr_load, tmr_en, tmr_exp;
    action_t     act;

    round_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .en     (tmr_en),
        .limit  ((state == ST_HOLD) ? HOLD_LIM : FIGHT_LIM),
        .expire (tmr_exp)
    );

    always_comb begin
        state_n  = state;
        wins1_n  = wins1;
        wins2_n  = wins2;
        round_n  = round_num;
        winner_n = winner;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        act      = judge(lives1, lives2, tmr_exp);
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n  = ST_CLEAR;
                    wins1_n  = 2'd0;
                    wins2_n  = 2'd0;
                    round_n  = 2'd1;
                    winner_n = WIN_NONE;
                end
            end
            ST_CLEAR: begin
                tmr_load = 1'b1;
                state_n  = ST_FIGHT;
            end
            ST_FIGHT: begin
                tmr_en = 1'b1;
                if (act != ACT_NONE) begin
                    // Restart the timer so it measures the hold period.
                    tmr_load = 1'b1;
                    state_n  = ST_HOLD;
                    if (act == ACT_P1_PT && wins1 != R2W) wins1_n = wins1 + 2'd1;
                    if (act == ACT_P2_PT && wins2 != R2W) wins2_n = wins2 + 2'd1;
                end
            end
            ST_HOLD: begin
                tmr_en = 1'b1;
                if (tmr_exp) begin
                    if (wins1 == R2W || wins2 == R2W || round_num == 2'd3) begin
                        state_n = ST_DONE;
                        if (wins1 > wins2)      winner_n = WIN_P1;
                        else if (wins2 > wins1) winner_n = WIN_P2;
                        else                    winner_n = WIN_DRAW;
                    end else begin
                        state_n = ST_CLEAR;
                        round_n = round_num + 2'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Stage controls are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            wins1        <= 2'd0;
            wins2        <= 2'd0;
            round_num    <= 2'd0;
            winner       <= WIN_NONE;
            game_reset_n <= 1'b0;
            game_control <= 1'b0;
            match_done   <= 1'b0;
        end else begin
            state        <= state_n;
            wins1        <= wins1_n;
            wins2        <= wins2_n;
            round_num    <= round_n;
            winner       <= winner_n;
            game_reset_n <= (state_n == ST_FIGHT) || (state_n == ST_HOLD);
            game_control <= (state_n == ST_FIGHT);
            match_done   <= (state_n == ST_DONE);
        end
    end

endmodule
